core_supervisor: RTL

//  Job sequencer that sits directly upstream of the processing cores (core_0..core_N-1).
//  - Launches a matrix-multiply job: drives each core's 2-bit status input.
//  - Collects each core's end_process and reports job completion, abort or timeout to the host side.
//  - Counts job cycles for performance readout.

---
 rtl/core_pkg.sv | 17 +
 rtl/sat_counter.sv | 33 +++
 rtl/core_supervisor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared status encodings and supervisor state type
package core_pkg;

  localparam int STATUS_W = 2;

  localparam logic [STATUS_W-1:0] STATUS_HOLD = 2'b00;
  localparam logic [STATUS_W-1:0] STATUS_RUN  = 2'b01;
  localparam logic [STATUS_W-1:0] STATUS_STOP = 2'b10;

  typedef enum logic [1:0] {
    SUP_IDLE   = 2'd0,
    SUP_LAUNCH = 2'd1,
    SUP_RUN    = 2'd2,
    SUP_DONE   = 2'd3
  } sup_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         enable_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/core_supervisor.sv
// rtl/core_supervisor.sv - launches a multi-core job, collects per-core completion
// and reports done/abort/timeout with a RUN cycle count
module core_supervisor
  import core_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [3:0]                    num_active,
  input  logic [NUM_CORES-1:0]          end_process,
  output logic [STATUS_W*NUM_CORES-1:0] status,
  output logic                          busy,
  output logic                          done,
  output logic                          timed_out,
  output logic                          aborted,
  output logic [NUM_CORES-1:0]          done_mask,
  output logic [CNT_W-1:0]              cycle_count
);

  sup_state_e                    state_q, state_d;
  logic [3:0]                    act_q, act_d;
  logic [NUM_CORES-1:0]          mask_q, mask_d;
  logic [NUM_CORES-1:0]          active;
  logic [STATUS_W*NUM_CORES-1:0] status_q, status_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          to_q, to_d;
  logic                          ab_q, ab_d;
  logic                          cnt_clear, cnt_en;
  logic                          timeout_hit;
  logic [3:0]                    act_clamped;

  assign act_clamped = (int'(num_active) > NUM_CORES) ? 4'(NUM_CORES) : num_active;
  assign timeout_hit = (MAX_CYCLES != 0) && (cycle_count == CNT_W'(MAX_CYCLES - 1));

  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      active[k] = (int'(act_q) > k);
    end
  end

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    mask_d    = mask_q;
    status_d  = status_q;
    to_d      = to_q;
    ab_d      = ab_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      SUP_IDLE, SUP_DONE: begin
        if (start) begin
          state_d   = SUP_LAUNCH;
          act_d     = act_clamped;
          mask_d    = '0;
          to_d      = 1'b0;
          ab_d      = 1'b0;
          cnt_clear = 1'b1;
          status_d  = '0;
        end
      end
      SUP_LAUNCH: begin
        state_d = (act_q == 4'd0) ? SUP_DONE : SUP_RUN;
        for (int k = 0; k < NUM_CORES; k++) begin
          status_d[STATUS_W*k +: STATUS_W] = active[k] ? STATUS_RUN : STATUS_HOLD;
        end
      end
      SUP_RUN: begin
        cnt_en = 1'b1;
        mask_d = mask_q | (end_process & active);
        if (abort) begin
          ab_d    = 1'b1;
          state_d = SUP_DONE;
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          state_d = SUP_DONE;
        end else if ((mask_d & active) == active) begin
          state_d = SUP_DONE;
        end
        // Leaving RUN forces every active core to STOP, whatever its mask bit.
        for (int k = 0; k < NUM_CORES; k++) begin
          if (!active[k]) begin
            status_d[STATUS_W*k +: STATUS_W] = STATUS_HOLD;
          end else if ((state_d == SUP_DONE) || mask_d[k]) begin
            status_d[STATUS_W*k +: STATUS_W] = STATUS_STOP;
          end else begin
            status_d[STATUS_W*k +: STATUS_W] = STATUS_RUN;
          end
        end
      end
      default: state_d = SUP_IDLE;
    endcase
    busy_d = (state_d == SUP_LAUNCH) || (state_d == SUP_RUN);
    done_d = (state_d == SUP_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= SUP_IDLE;
      act_q    <= '0;
      mask_q   <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      ab_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      mask_q   <= mask_d;
      status_q <= status_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      to_q     <= to_d;
      ab_q     <= ab_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .count_o  (cycle_count)
  );

  assign status    = status_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timed_out = to_q;
  assign aborted   = ab_q;
  assign done_mask = mask_q;

endmodule
